// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority pointer and registered one-hot grants.
// An owner keeps the grant until it releases, or is preempted after HOLD_MAX cycles if others wait.
module rr_onehot_arbiter #(
  parameter int N        = 8,
  parameter int IDW      = 3,
  parameter int HOLD_MAX = 15
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           enable,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic [N-1:0]   ptr
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [N-1:0] ONE       = N'(1);
  localparam logic [7:0]   HOLD_LAST = 8'(HOLD_MAX - 1);

  state_t         state, stateNext;
  logic [N-1:0]   gntNext;
  logic [7:0]     holdCnt, holdNext;
  logic           load;
  logic           ownerReq;
  logic           othersReq;

  // Lowest set request at or above the pointer, else wrap to the lowest set request overall.
  function automatic logic [N-1:0] sel(input logic [N-1:0] r, input logic [N-1:0] p);
    logic [N-1:0] upper;
    upper = r & ~(p - ONE);
    if (upper != '0) return upper & (~upper + ONE);
    return r & (~r + ONE);
  endfunction

  function automatic logic [IDW-1:0] encode(input logic [N-1:0] g);
    logic [IDW-1:0] id;
    id = '0;
    for (int i = 0; i < N; i++)
      if (g[i]) id = IDW'(i);
    return id;
  endfunction

  assign ownerReq  = |(req & gnt);
  assign othersReq = |(req & ~gnt);

  always_comb begin
    stateNext = state;
    gntNext   = gnt;
    holdNext  = holdCnt;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (enable && (req != '0)) begin
          gntNext   = sel(req, ptr);
          holdNext  = '0;
          load      = 1'b1;
          stateNext = OWN;
        end
      end
      OWN: begin
        // Release or expired hold: hand off if allowed; a blocked preempt just keeps the saturated count.
        if (!ownerReq || ((holdCnt == HOLD_LAST) && othersReq)) begin
          if (enable && othersReq) begin
            gntNext  = sel(req & ~gnt, ptr);
            holdNext = '0;
            load     = 1'b1;
          end else if (!ownerReq) begin
            gntNext   = '0;
            holdNext  = '0;
            stateNext = IDLE;
          end
        end else if (holdCnt != HOLD_LAST) begin
          holdNext = holdCnt + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      ptr       <= ONE;
      holdCnt   <= '0;
    end else begin
      state     <= stateNext;
      gnt       <= gntNext;
      gnt_valid <= |gntNext;
      gnt_id    <= encode(gntNext);
      holdCnt   <= holdNext;
      if (load) ptr <= {gntNext[N-2:0], gntNext[N-1]};
    end
  end

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Self-checking bench for rr_onehot_arbiter: vector table plus hand-written multi-cycle sequences,
// with expected outputs queued when stimulus is driven and popped one cycle later.
module tb_rr_onehot_arbiter;

  localparam int N        = 8;
  localparam int IDW      = 3;
  localparam int HOLD_MAX = 4;

  logic           clk     = 1'b0;
  logic           reset_n = 1'b0;
  logic           enable  = 1'b0;
  logic [N-1:0]   req     = '0;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  logic [N-1:0]   ptr;

  typedef struct {
    logic         rstn;
    logic         en;
    logic [N-1:0] req;
    logic [N-1:0] expGnt;
    logic [N-1:0] expPtr;
    string        tag;
  } vec_t;

  typedef struct {
    logic [N-1:0] gnt;
    logic [N-1:0] ptr;
    string        tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checkCount = 0;
  int   passCount  = 0;

  always #5 clk = ~clk;

  rr_onehot_arbiter #(.N(N), .IDW(IDW), .HOLD_MAX(HOLD_MAX)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .ptr       (ptr)
  );

  function automatic logic [N-1:0] idOf(input logic [N-1:0] g);
    logic [N-1:0] id;
    id = '0;
    for (int i = 0; i < N; i++)
      if (g[i]) id = N'(i);
    return id;
  endfunction

  function automatic logic [N-1:0] rotl(input logic [N-1:0] x);
    return {x[N-2:0], x[N-1]};
  endfunction

  task automatic compare(input string name, input logic [N-1:0] got, input logic [N-1:0] want);
    checkCount++;
    if (got === want) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  task automatic addVec(input logic rstn, input logic en, input logic [N-1:0] r,
                        input logic [N-1:0] eg, input logic [N-1:0] ep, input string tag);
    vec_t v;
    v.rstn = rstn; v.en = en; v.req = r; v.expGnt = eg; v.expPtr = ep; v.tag = tag;
    vecs.push_back(v);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checkCount++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    compare({e.tag, ".gnt"}, gnt, e.gnt);
    compare({e.tag, ".gnt_valid"}, N'(gnt_valid), N'(|e.gnt));
    compare({e.tag, ".gnt_id"}, N'(gnt_id), idOf(e.gnt));
    compare({e.tag, ".ptr"}, ptr, e.ptr);
    compare({e.tag, ".ptr_onehot"}, N'($onehot(ptr)), N'(1));
  endtask

  task automatic applyStimulus(input logic rstn, input logic en, input logic [N-1:0] r,
                               input logic [N-1:0] eg, input logic [N-1:0] ep, input string tag);
    exp_t e;
    reset_n = rstn;
    enable  = en;
    req     = r;
    e.gnt = eg; e.ptr = ep; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    // Reset, basic grant, enable gating, reset mid-grant, empty and wrapped selection.
    addVec(0, 1, 8'h01, 8'h00, 8'h01, "rst0");
    addVec(0, 1, 8'h01, 8'h00, 8'h01, "rst1");
    addVec(1, 1, 8'h01, 8'h01, 8'h02, "basic_grant");
    addVec(1, 1, 8'h00, 8'h00, 8'h02, "basic_release");
    addVec(1, 1, 8'h08, 8'h08, 8'h10, "en_grant3");
    addVec(1, 0, 8'h48, 8'h08, 8'h10, "en_hold3");
    addVec(1, 0, 8'h40, 8'h00, 8'h10, "en_release_blocked");
    addVec(1, 0, 8'h40, 8'h00, 8'h10, "en_still_idle");
    addVec(1, 1, 8'h40, 8'h40, 8'h80, "en_resume6");
    addVec(1, 0, 8'h41, 8'h40, 8'h80, "en_hold_a");
    addVec(1, 0, 8'h41, 8'h40, 8'h80, "en_hold_b");
    addVec(1, 0, 8'h41, 8'h40, 8'h80, "en_hold_c");
    addVec(1, 0, 8'h41, 8'h40, 8'h80, "en_preempt_blocked");
    addVec(1, 1, 8'h41, 8'h01, 8'h02, "en_preempt_now");
    addVec(1, 1, 8'h00, 8'h00, 8'h02, "en_drop");
    addVec(1, 1, 8'h10, 8'h10, 8'h20, "mid_grant4");
    addVec(0, 1, 8'h10, 8'h00, 8'h01, "mid_reset");
    addVec(1, 1, 8'h11, 8'h01, 8'h02, "mid_after_reset");
    addVec(1, 1, 8'h10, 8'h10, 8'h20, "mid_handoff4");
    addVec(1, 1, 8'h00, 8'h00, 8'h20, "mid_drop");
    addVec(1, 1, 8'h00, 8'h00, 8'h20, "empty_a");
    addVec(1, 1, 8'h00, 8'h00, 8'h20, "empty_b");
    addVec(1, 1, 8'h90, 8'h80, 8'h01, "simul_grant7");
    addVec(1, 1, 8'h10, 8'h10, 8'h20, "simul_grant4");
    addVec(1, 1, 8'h00, 8'h00, 8'h20, "simul_drop");

    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i].rstn, vecs[i].en, vecs[i].req, vecs[i].expGnt, vecs[i].expPtr, vecs[i].tag);

    // Fairness: all request, each owner drops its bit for one cycle; order 0..7 then 0.
    applyStimulus(0, 1, 8'h00, 8'h00, 8'h01, "fair_rst");
    applyStimulus(1, 1, 8'hFF, 8'h01, 8'h02, "fair_first");
    for (int k = 0; k < N; k++) begin
      logic [N-1:0] cur;
      cur = N'(1) << k;
      applyStimulus(1, 1, 8'hFF & ~cur, rotl(cur), rotl(rotl(cur)), $sformatf("fair_step%0d", k));
    end
    applyStimulus(1, 1, 8'h00, 8'h00, 8'h02, "fair_end");

    // Preemption after HOLD_MAX cycles once requester 5 is waiting.
    applyStimulus(0, 1, 8'h00, 8'h00, 8'h01, "pre_rst");
    applyStimulus(1, 1, 8'h01, 8'h01, 8'h02, "pre_c0");
    applyStimulus(1, 1, 8'h01, 8'h01, 8'h02, "pre_c1");
    applyStimulus(1, 1, 8'h21, 8'h01, 8'h02, "pre_c2");
    applyStimulus(1, 1, 8'h21, 8'h01, 8'h02, "pre_c3");
    applyStimulus(1, 1, 8'h21, 8'h20, 8'h40, "pre_handoff");
    applyStimulus(1, 1, 8'h00, 8'h00, 8'h40, "pre_drop");

    // A lone owner is never preempted.
    applyStimulus(0, 1, 8'h00, 8'h00, 8'h01, "lone_rst");
    applyStimulus(1, 1, 8'h01, 8'h01, 8'h02, "lone_grant");
    for (int k = 0; k < 3 * HOLD_MAX; k++)
      applyStimulus(1, 1, 8'h01, 8'h01, 8'h02, $sformatf("lone_hold%0d", k));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
